// File: rtl/tnn_seq_neuron_if.sv
// Stream bundle for tnn_seq_neuron: one W-bit input channel (threshold beat,
// then operand beats) and one result channel carrying the decision bit and
// the debug sum.
interface tnn_seq_neuron_if #(
  parameter int W  = 3,
  parameter int SW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic [SW-1:0] out_sum;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_sum
  );

  // Neuron side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_sum
  );
endinterface

// File: rtl/tnn_seq_neuron.sv
// Sequential threshold neuron. Takes a threshold beat followed by N operand
// beats, accumulates the operands and emits a one-bit decision plus the sum.
// POL=0: out_bit = thr > sum ; POL=1: out_bit = sum >= thr (unsigned).
// Optional build macro TNN_APPROX_LSB_EN: clears operand bit 0 before
// accumulation (threshold untouched).
module tnn_seq_neuron #(
  parameter int W   = 3,
  parameter int N   = 4,
  parameter int POL = 0
) (
  input  logic              clk,
  input  logic              rst,
  tnn_seq_neuron_if.slave   bus
);
  // Accumulator carries at least one extra bit so N*(2^W-1) always fits.
  localparam int SW = W + ((N > 1) ? $clog2(N) : 1);
  // Counter must reach N without wrapping.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  thr_q,   thr_d;
  logic [SW-1:0] acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [SW-1:0] sum_q,   sum_d;
  logic          bit_q,   bit_d;

  logic          in_ready_w;
  logic          out_valid_w;
  logic          in_fire;
  logic          out_fire;
  logic [W-1:0]  op_w;
  logic [SW-1:0] acc_nxt;
  logic [SW-1:0] thr_ext;
  logic          dec_nxt;

  // Input is never accepted while in reset or while a result is pending,
  // so input and output transfers never share a cycle.
  assign in_ready_w  = ~rst & (state_q != OUT);
  assign out_valid_w = (state_q == OUT);
  assign in_fire     = bus.in_valid & in_ready_w;
  assign out_fire    = out_valid_w & bus.out_ready;

`ifdef TNN_APPROX_LSB_EN
  assign op_w = bus.in_data & ~W'(1);
`else
  assign op_w = bus.in_data;
`endif

  // Decision is taken on the running sum including the beat being accepted,
  // so the result can be registered on the same edge as the last operand.
  assign acc_nxt = acc_q + SW'(op_w);
  assign thr_ext = SW'(thr_q);
  assign dec_nxt = (POL != 0) ? (acc_nxt >= thr_ext) : (thr_ext > acc_nxt);

  // Next-state and datapath update; everything holds unless a beat transfers.
  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          thr_d   = bus.in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_fire) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            sum_d   = acc_nxt;
            bit_d   = dec_nxt;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any partial transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      thr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_bit   = bit_q;
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_tnn_seq_neuron.sv
// Randomized bench for tnn_seq_neuron (W=3, N=4). Two instances share the
// input stream: one with POL=0, one with POL=1. Expected results come from a
// plain-arithmetic model of the neuron rules.
module tb_tnn_seq_neuron;
  localparam int W  = 3;
  localparam int N  = 4;
  localparam int SW = 5;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tnn_seq_neuron_if #(.W(W), .SW(SW)) bus  ();
  tnn_seq_neuron_if #(.W(W), .SW(SW)) bus1 ();

  assign bus1.in_valid  = bus.in_valid;
  assign bus1.in_data   = bus.in_data;
  assign bus1.out_ready = bus.out_ready;

  tnn_seq_neuron #(.W(W), .N(N), .POL(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus));
  tnn_seq_neuron #(.W(W), .N(N), .POL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Effective operand value as the neuron should see it.
  function automatic int op_eff(input int v);
`ifdef TNN_APPROX_LSB_EN
    return v - (v % 2);
`else
    return v;
`endif
  endfunction

  // Present one beat (after a random idle gap) and let it transfer.
  task automatic beat(input int d);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = W'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = W'(d);
    chk("in_ready_acc", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_rst();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_bit",   32'(bus.out_bit),   0);
    chk("rst_out_sum",   32'(bus.out_sum),   0);
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready",  32'(bus.in_ready),  1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
  endtask

  // Full transaction: threshold, N operands, hold result for `hold` cycles.
  task automatic txn(input int thr, input int ops[N], input int hold);
    int s;
    int e0, e1;
    s = 0;
    foreach (ops[i]) s += op_eff(ops[i]);
    e0 = (thr > s) ? 1 : 0;
    e1 = (s >= thr) ? 1 : 0;
    bus.out_ready = 1'b0;
    beat(thr);
    for (int i = 0; i < N; i++) begin
      chk("early_out_valid", 32'(bus.out_valid), 0);
      beat(ops[i]);
    end
    chk("lat_out_valid", 32'(bus.out_valid), 1);
    chk("out_sum",       32'(bus.out_sum),   32'(s));
    chk("out_bit_pol0",  32'(bus.out_bit),   32'(e0));
    chk("out_sum_pol1",  32'(bus1.out_sum),  32'(s));
    chk("out_bit_pol1",  32'(bus1.out_bit),  32'(e1));
    chk("out_in_ready",  32'(bus.in_ready),  0);
    for (int h = 0; h < hold; h++) begin
      // Offer a stray input beat; it must be ignored while the result waits.
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_out_sum",   32'(bus.out_sum),   32'(s));
      chk("hold_out_bit",   32'(bus.out_bit),   32'(e0));
      chk("hold_in_ready",  32'(bus.in_ready),  0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("done_out_valid", 32'(bus.out_valid), 0);
    chk("done_in_ready",  32'(bus.in_ready),  1);
  endtask

  initial begin
    int ops[N];
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    do_rst();

    txn(5, '{1, 1, 1, 1}, 0);
    txn(4, '{1, 1, 1, 1}, 1);
    txn(7, '{7, 7, 7, 7}, 2);
    txn(2, '{0, 3, 5, 6}, 3);

    // Reset in the middle of accumulation.
    beat(6);
    beat(1);
    beat(2);
    do_rst();
    txn(3, '{0, 0, 1, 0}, 0);

    // Reset while a result is pending.
    beat(0);
    for (int i = 0; i < N; i++) beat(4);
    chk("pend_out_valid", 32'(bus.out_valid), 1);
    do_rst();

    txn(1, '{1, 1, 1, 1}, 1);
    txn(0, '{0, 0, 0, 0}, 0);

    for (int t = 0; t < 25; t++) begin
      foreach (ops[i]) ops[i] = int'($urandom_range(0, 7));
      txn(int'($urandom_range(0, 7)), ops, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
